// File: rtl/ov7620_pkg.sv
// rtl/ov7620_pkg.sv - shared types, mode codes and default OV7620 timing
package ov7620_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VS,
    ST_VBP,
    ST_ACT,
    ST_VFP
  } state_t;

  localparam logic [1:0] MODE_RAMP    = 2'd0;
  localparam logic [1:0] MODE_BARS    = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_CONST   = 2'd3;

  localparam int X_W    = 11;
  localparam int LINE_W = 10;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_BLANK   = 144;
  localparam int DEF_V_ACTIVE  = 240;
  localparam int DEF_VS_LINES  = 3;
  localparam int DEF_VBP_LINES = 16;
  localparam int DEF_VFP_LINES = 4;
  localparam int DEF_PCLK_HALF = 2;

  // Only the pixel bits each pattern actually consumes are passed in.
  function automatic logic [7:0] pixel_value(input logic [1:0] mode,
                                             input logic [8:0] px,
                                             input logic       py5,
                                             input logic [7:0] level);
    case (mode)
      MODE_RAMP:    return px[7:0];
      MODE_BARS:    return {px[8:6], 5'b0};
      MODE_CHECKER: return (px[5] ^ py5) ? 8'hFF : 8'h00;
      default:      return level;
    endcase
  endfunction

endpackage

// File: rtl/ov7620_pclk_div.sv
// rtl/ov7620_pclk_div.sv - PCLK divider; tick marks the CLK cycle where PCLK falls
module ov7620_pclk_div #(
  parameter int PCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pclk,
  output logic tick
);

  localparam int CW = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PCLK_HALF - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == CNT_LAST);
  assign tick = wrap && pclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      pclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      pclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      pclk <= ~pclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ov7620_stream_gen.sv
// rtl/ov7620_stream_gen.sv - OV7620 sensor emulator producing PCLK/HREF/VSYNC/Y_Data
module ov7620_stream_gen
  import ov7620_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_BLANK   = DEF_H_BLANK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int VS_LINES  = DEF_VS_LINES,
  parameter int VBP_LINES = DEF_VBP_LINES,
  parameter int VFP_LINES = DEF_VFP_LINES,
  parameter int PCLK_HALF = DEF_PCLK_HALF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [1:0] Mode,
  input  logic [7:0] Level,
  output logic       PCLK,
  output logic       HREF,
  output logic       VSYNC,
  output logic [7:0] Y_Data,
  output logic       Frame_Done,
  output logic       Busy,
  output logic [7:0] Frame_Cnt
);

  localparam logic [X_W-1:0]    X_LAST   = X_W'(H_ACTIVE + H_BLANK - 1);
  localparam logic [X_W-1:0]    X_ACT    = X_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] VS_LAST  = LINE_W'(VS_LINES - 1);
  localparam logic [LINE_W-1:0] VBP_LAST = LINE_W'(VBP_LINES - 1);
  localparam logic [LINE_W-1:0] ACT_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] VFP_LAST = LINE_W'(VFP_LINES - 1);

  state_t              state, state_nxt;
  logic [X_W-1:0]      x;
  logic [LINE_W-1:0]   line, line_last;
  logic                tick, line_end, state_end, frame_end, latch;
  logic [1:0]          mode_q;
  logic [7:0]          level_q;

  ov7620_pclk_div #(.PCLK_HALF(PCLK_HALF)) u_div (
    .clk  (CLK),
    .rst  (RST),
    .en   (state != ST_IDLE),
    .pclk (PCLK),
    .tick (tick)
  );

  always_comb begin
    line_last = VFP_LAST;
    case (state)
      ST_VS:   line_last = VS_LAST;
      ST_VBP:  line_last = VBP_LAST;
      ST_ACT:  line_last = ACT_LAST;
      default: line_last = VFP_LAST;
    endcase
  end

  assign line_end  = tick && (x == X_LAST);
  assign state_end = line_end && (line == line_last);
  assign frame_end = state_end && (state == ST_VFP);
  // Mode/Level are captured only when a frame is about to start.
  assign latch     = EN && ((state == ST_IDLE) || frame_end);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (EN)        state_nxt = ST_VS;
      ST_VS:   if (state_end) state_nxt = ST_VBP;
      ST_VBP:  if (state_end) state_nxt = ST_ACT;
      ST_ACT:  if (state_end) state_nxt = ST_VFP;
      ST_VFP:  if (state_end) state_nxt = EN ? ST_VS : ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy   = (state != ST_IDLE);
    VSYNC  = (state == ST_VS);
    HREF   = (state == ST_ACT) && (x < X_ACT);
    Y_Data = 8'h00;
    if (HREF) Y_Data = pixel_value(mode_q, x[8:0], line[5], level_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x    <= '0;
      line <= '0;
    end else if (state == ST_IDLE) begin
      x    <= '0;
      line <= '0;
    end else if (line_end) begin
      x    <= '0;
      line <= state_end ? '0 : line + 1'b1;
    end else if (tick) begin
      x <= x + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q  <= MODE_RAMP;
      level_q <= 8'h00;
    end else if (latch) begin
      mode_q  <= Mode;
      level_q <= Level;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Frame_Done <= 1'b0;
      Frame_Cnt  <= 8'h00;
    end else begin
      Frame_Done <= frame_end;
      if (frame_end) Frame_Cnt <= Frame_Cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ov7620_stream_gen.sv
// tb/tb_ov7620_stream_gen.sv - scoreboard bench for ov7620_stream_gen
module tb_ov7620_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] model_pix(input int mode, input int px, input int py,
                                           input logic [7:0] lvl);
    case (mode)
      0:       model_pix = 8'(px % 256);
      1:       model_pix = 8'(((px / 64) % 8) * 32);
      2:       model_pix = (((px / 32) % 2) != ((py / 32) % 2)) ? 8'hFF : 8'h00;
      default: model_pix = lvl;
    endcase
  endfunction

  // A: tiny timing; B: full-width lines, checker; C: full-width lines, bars, PCLK_HALF=2
  logic       rst_a, en_a, pclk_a, href_a, vsync_a, fd_a, busy_a;
  logic [1:0] mode_a;
  logic [7:0] level_a, y_a, fcnt_a;
  logic       rst_b, en_b, pclk_b, href_b, vsync_b, fd_b, busy_b;
  logic [1:0] mode_b;
  logic [7:0] level_b, y_b, fcnt_b;
  logic       rst_c, en_c, pclk_c, href_c, vsync_c, fd_c, busy_c;
  logic [1:0] mode_c;
  logic [7:0] level_c, y_c, fcnt_c;

  ov7620_stream_gen #(.H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VS_LINES(1),
                      .VBP_LINES(1), .VFP_LINES(1), .PCLK_HALF(1)) dut_a (
    .CLK(clk), .RST(rst_a), .EN(en_a), .Mode(mode_a), .Level(level_a),
    .PCLK(pclk_a), .HREF(href_a), .VSYNC(vsync_a), .Y_Data(y_a),
    .Frame_Done(fd_a), .Busy(busy_a), .Frame_Cnt(fcnt_a));

  ov7620_stream_gen #(.H_ACTIVE(640), .H_BLANK(144), .V_ACTIVE(33), .VS_LINES(3),
                      .VBP_LINES(1), .VFP_LINES(1), .PCLK_HALF(1)) dut_b (
    .CLK(clk), .RST(rst_b), .EN(en_b), .Mode(mode_b), .Level(level_b),
    .PCLK(pclk_b), .HREF(href_b), .VSYNC(vsync_b), .Y_Data(y_b),
    .Frame_Done(fd_b), .Busy(busy_b), .Frame_Cnt(fcnt_b));

  ov7620_stream_gen #(.H_ACTIVE(640), .H_BLANK(4), .V_ACTIVE(2), .VS_LINES(1),
                      .VBP_LINES(1), .VFP_LINES(1), .PCLK_HALF(2)) dut_c (
    .CLK(clk), .RST(rst_c), .EN(en_c), .Mode(mode_c), .Level(level_c),
    .PCLK(pclk_c), .HREF(href_c), .VSYNC(vsync_c), .Y_Data(y_c),
    .Frame_Done(fd_c), .Busy(busy_c), .Frame_Cnt(fcnt_c));

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  task automatic push_a(input int mode, input logic [7:0] lvl);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) qa.push_back(model_pix(mode, x, y, lvl));
  endtask

  // ---------------- monitor A: pixels, line/frame timing, Frame_Done, Frame_Cnt
  logic       pa_prev = 0, ha_prev = 0, fa_prev = 0;
  logic [7:0] fc_exp_a = 0;
  int vs_na = 0, h_na = 0, p_na = 0, hl_a = 0, fdw_a = 0;

  initial forever begin
    @(negedge clk);
    if (rst_a) begin
      vs_na = 0; h_na = 0; p_na = 0; hl_a = 0; fdw_a = 0;
      pa_prev = 0; ha_prev = 0; fa_prev = 0; fc_exp_a = 0;
    end else begin
      if (pclk_a && !pa_prev) begin
        p_na++;
        if (vsync_a) vs_na++;
        if (href_a) begin
          hl_a++;
          if (qa.size() == 0) check_eq("pix_a_unexpected", 32'(href_a), 0);
          else check_eq("pix_a", 32'(y_a), 32'(qa.pop_front()));
        end else begin
          check_eq("y_blank_a", 32'(y_a), 0);
          if (ha_prev) begin
            check_eq("href_len_a", hl_a, 8);
            h_na++;
            hl_a = 0;
          end
        end
        ha_prev = href_a;
      end
      if (fd_a) fdw_a++;
      else if (fdw_a != 0) begin
        check_eq("fd_width_a", fdw_a, 1);
        fdw_a = 0;
      end
      if (fd_a && !fa_prev) begin
        fc_exp_a = fc_exp_a + 8'd1;
        check_eq("fcnt_a", 32'(fcnt_a), 32'(fc_exp_a));
        check_eq("vs_pclks_a", vs_na, 12);
        check_eq("href_pulses_a", h_na, 4);
        check_eq("frame_pclks_a", p_na, 84);
        vs_na = 0; h_na = 0; p_na = 0;
      end
      pa_prev = pclk_a;
      fa_prev = fd_a;
    end
  end

  // ---------------- monitor B
  logic pb_prev = 0, hb_prev = 0;
  int vs_nb = 0, l_nb = 0, hl_b = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_b && pclk_b && !pb_prev) begin
      if (vsync_b) vs_nb++;
      if (href_b) begin
        hl_b++;
        if (qb.size() == 0) check_eq("pix_b_unexpected", 32'(href_b), 0);
        else check_eq("pix_b", 32'(y_b), 32'(qb.pop_front()));
      end else if (hb_prev) begin
        check_eq("href_len_b", hl_b, 640);
        l_nb++;
        hl_b = 0;
      end
      hb_prev = href_b;
    end
    if (!rst_b && fd_b) begin
      check_eq("vs_pclks_b", vs_nb, 3 * 784);
      check_eq("lines_b", l_nb, 33);
      check_eq("sb_left_b", qb.size(), 0);
    end
    pb_prev = pclk_b;
  end

  // ---------------- monitor C
  logic pc_prev = 0, hc_prev = 0;
  int vs_nc = 0, l_nc = 0, hl_c = 0, phi_c = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_c) begin
      if (pclk_c) phi_c++;
      else if (phi_c != 0) begin
        check_eq("pclk_high_c", phi_c, 2);
        phi_c = 0;
      end
      if (pclk_c && !pc_prev) begin
        if (vsync_c) vs_nc++;
        if (href_c) begin
          hl_c++;
          if (qc.size() == 0) check_eq("pix_c_unexpected", 32'(href_c), 0);
          else check_eq("pix_c", 32'(y_c), 32'(qc.pop_front()));
        end else if (hc_prev) begin
          check_eq("href_len_c", hl_c, 640);
          l_nc++;
          hl_c = 0;
        end
        hc_prev = href_c;
      end
      if (fd_c) begin
        check_eq("vs_pclks_c", vs_nc, 644);
        check_eq("lines_c", l_nc, 2);
        check_eq("sb_left_c", qc.size(), 0);
      end
    end
    pc_prev = pclk_c;
  end

  // ---------------- stimulus helpers for A
  task automatic wait_fd_a(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd_a && n < budget);
    check_eq("fd_a_seen", 32'(fd_a), 1);
  endtask

  task automatic wait_href_rise_a(input int count, input int budget);
    int n = 0, r = 0;
    logic prev = href_a;
    while (r < count && n < budget) begin
      @(negedge clk);
      n++;
      if (href_a && !prev) r++;
      prev = href_a;
    end
    check_eq("href_a_rise_seen", r, count);
  endtask

  task automatic check_outputs_zero_a(input string tag);
    check_eq({tag, "_pclk"},  32'(pclk_a),  0);
    check_eq({tag, "_href"},  32'(href_a),  0);
    check_eq({tag, "_vsync"}, 32'(vsync_a), 0);
    check_eq({tag, "_y"},     32'(y_a),     0);
    check_eq({tag, "_fd"},    32'(fd_a),    0);
    check_eq({tag, "_busy"},  32'(busy_a),  0);
    check_eq({tag, "_fcnt"},  32'(fcnt_a),  0);
  endtask

  task automatic run_a();
    logic saw;
    int   last;
    rst_a = 1; en_a = 0; mode_a = 2'd0; level_a = 8'h00;
    repeat (2) @(negedge clk);
    check_outputs_zero_a("reset");
    rst_a = 0;
    repeat (5) @(negedge clk);
    check_eq("idle_busy", 32'(busy_a), 0);
    check_eq("idle_pclk", 32'(pclk_a), 0);

    // constant frame with Mode/Level changed mid-frame, then a ramp frame
    mode_a = 2'd3; level_a = 8'h5A;
    push_a(3, 8'h5A);
    push_a(0, 8'h00);
    en_a = 1;
    wait_href_rise_a(1, 400);
    mode_a = 2'd0; level_a = 8'h33;
    wait_fd_a(400);
    wait_href_rise_a(3, 400);
    en_a = 0;
    wait_fd_a(400);
    check_eq("busy_fall", 32'(busy_a), 0);
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      saw = saw | pclk_a | vsync_a | busy_a;
    end
    check_eq("idle_quiet", 32'(saw), 0);

    // asynchronous reset while HREF is high
    push_a(0, 8'h00);
    en_a = 1;
    wait_href_rise_a(2, 400);
    check_eq("href_before_rst", 32'(href_a), 1);
    #2 rst_a = 1;
    #1 check_outputs_zero_a("midline_rst");
    qa.delete();
    repeat (2) @(negedge clk);
    for (int f = 0; f < 256; f++) push_a(0, 8'h00);
    rst_a = 0;
    @(negedge clk);
    check_eq("restart_vsync", 32'(vsync_a), 1);
    check_eq("restart_busy",  32'(busy_a),  1);
    check_eq("restart_href",  32'(href_a),  0);

    // 256 back-to-back frames: Frame_Cnt wraps; an EN glitch must not add a gap
    last = 0;
    for (int k = 1; k <= 256; k++) begin
      wait_fd_a(400);
      if (k > 1) check_eq("frame_gap", cyc - last, 168);
      last = cyc;
      if (k == 100) begin
        wait_href_rise_a(1, 400);
        en_a = 0;
        repeat (10) @(negedge clk);
        en_a = 1;
      end
      if (k == 255) en_a = 0;
    end
    check_eq("fcnt_wrap", 32'(fcnt_a), 0);
    @(negedge clk);
    check_eq("wrap_idle_busy", 32'(busy_a), 0);
  endtask

  task automatic run_b();
    int n = 0;
    rst_b = 1; en_b = 0; mode_b = 2'd2; level_b = 8'h00;
    repeat (3) @(negedge clk);
    for (int y = 0; y < 33; y++)
      for (int x = 0; x < 640; x++) qb.push_back(model_pix(2, x, y, 8'h00));
    rst_b = 0; en_b = 1;
    repeat (4) @(negedge clk);
    en_b = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd_b && n < 62000);
    check_eq("fd_b_seen", 32'(fd_b), 1);
    check_eq("fcnt_b", 32'(fcnt_b), 1);
    @(negedge clk);
    check_eq("busy_b_idle", 32'(busy_b), 0);
  endtask

  task automatic run_c();
    int n = 0;
    rst_c = 1; en_c = 0; mode_c = 2'd1; level_c = 8'h77;
    repeat (3) @(negedge clk);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 640; x++) qc.push_back(model_pix(1, x, y, 8'h77));
    rst_c = 0; en_c = 1;
    repeat (4) @(negedge clk);
    en_c = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd_c && n < 14000);
    check_eq("fd_c_seen", 32'(fd_c), 1);
    repeat (3) @(negedge clk);
    check_eq("busy_c_idle", 32'(busy_c), 0);
    check_eq("pclk_c_idle", 32'(pclk_c), 0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
